// File: rtl/seg_display_sequencer.sv
// seg_display_sequencer
// Picks one nibble of the ALU result or flag byte for the 7-segment decoder.
// Modes 0..3 show one fixed digit live. Mode 4 auto-scans all four digits
// from a snapshot that is retaken at each wrap to digit 0. Modes 5..7 blank
// the display.
// Optional build macro: SEG_SCAN_GAP_EN adds one blank prescaler tick between
// auto-scan digits.
module seg_display_sequencer #(
  parameter int PRESC_DIV   = 1000,
  parameter int DWELL_TICKS = 250
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       ena,
  input  logic [7:0] alu_f,
  input  logic [7:0] alu_flags,
  input  logic [2:0] disp_sel,
  output logic [3:0] nibble,
  output logic       dp,
  output logic       blank,
  output logic [1:0] digit_idx,
  output logic       digit_strobe
);

  localparam int PW = $clog2(PRESC_DIV);
  localparam int DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC_DIV - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_TICKS - 1);
  localparam logic [2:0]    MODE_SCAN  = 3'd4;

  // Digits 0/1 come from the result byte, digits 2/3 from the flag byte.
  function automatic logic [3:0] pick_nibble(input logic [7:0] f,
                                             input logic [7:0] fl,
                                             input logic [1:0] idx);
    logic [3:0] n;
    case (idx)
      2'd0:    n = f[3:0];
      2'd1:    n = f[7:4];
      2'd2:    n = fl[3:0];
      default: n = fl[7:4];
    endcase
    return n;
  endfunction

  logic [2:0]    mode_q, mode_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    scan_q, scan_d;
  logic          gap_q, gap_d;
  logic [7:0]    snap_f_q, snap_f_d;
  logic [7:0]    snap_flags_q, snap_flags_d;
  logic [3:0]    nibble_q, nibble_d;
  logic          dp_q, dp_d;
  logic          blank_q, blank_d;
  logic [1:0]    idx_q, idx_d;
  logic          strobe_q, strobe_d;
  logic          tick;
  logic          advance;

  // Next-state: a mode change clears the counters and snapshots the inputs; otherwise auto-scan counts.
  always_comb begin
    mode_d       = mode_q;
    presc_d      = presc_q;
    dwell_d      = dwell_q;
    scan_d       = scan_q;
    gap_d        = gap_q;
    snap_f_d     = snap_f_q;
    snap_flags_d = snap_flags_q;
    nibble_d     = nibble_q;
    dp_d         = dp_q;
    blank_d      = blank_q;
    idx_d        = idx_q;
    strobe_d     = strobe_q;
    tick         = 1'b0;
    advance      = 1'b0;

    if (ena) begin
      if (disp_sel != mode_q) begin
        mode_d       = disp_sel;
        presc_d      = '0;
        dwell_d      = '0;
        scan_d       = 2'd0;
        gap_d        = 1'b0;
        snap_f_d     = alu_f;
        snap_flags_d = alu_flags;
      end else if (mode_q == MODE_SCAN) begin
        tick    = (presc_q == PRESC_LAST);
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (tick) begin
`ifdef SEG_SCAN_GAP_EN
          if (gap_q) begin
            gap_d   = 1'b0;
            advance = 1'b1;
          end else if (dwell_q == DWELL_LAST) begin
            dwell_d = '0;
            gap_d   = 1'b1;
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
`else
          if (dwell_q == DWELL_LAST) begin
            dwell_d = '0;
            advance = 1'b1;
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
`endif
        end
        if (advance) begin
          scan_d = scan_q + 1'b1;
          if (scan_q == 2'd3) begin
            snap_f_d     = alu_f;
            snap_flags_d = alu_flags;
          end
        end
      end

      strobe_d = advance;
      if (!mode_d[2]) begin
        nibble_d = pick_nibble(alu_f, alu_flags, mode_d[1:0]);
        dp_d     = mode_d[1];
        blank_d  = 1'b0;
        idx_d    = mode_d[1:0];
      end else if (mode_d == MODE_SCAN) begin
        idx_d = scan_d;
        if (gap_d) begin
          nibble_d = 4'h0;
          dp_d     = 1'b0;
          blank_d  = 1'b1;
        end else begin
          nibble_d = pick_nibble(snap_f_d, snap_flags_d, scan_d);
          dp_d     = scan_d[1];
          blank_d  = 1'b0;
        end
      end else begin
        nibble_d = 4'h0;
        dp_d     = 1'b0;
        blank_d  = 1'b1;
        idx_d    = 2'd0;
      end
    end
  end

  // State and registered outputs; async reset leaves the display blanked.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      mode_q       <= 3'd0;
      presc_q      <= '0;
      dwell_q      <= '0;
      scan_q       <= 2'd0;
      gap_q        <= 1'b0;
      snap_f_q     <= 8'h00;
      snap_flags_q <= 8'h00;
      nibble_q     <= 4'h0;
      dp_q         <= 1'b0;
      blank_q      <= 1'b1;
      idx_q        <= 2'd0;
      strobe_q     <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      presc_q      <= presc_d;
      dwell_q      <= dwell_d;
      scan_q       <= scan_d;
      gap_q        <= gap_d;
      snap_f_q     <= snap_f_d;
      snap_flags_q <= snap_flags_d;
      nibble_q     <= nibble_d;
      dp_q         <= dp_d;
      blank_q      <= blank_d;
      idx_q        <= idx_d;
      strobe_q     <= strobe_d;
    end
  end

  assign nibble       = nibble_q;
  assign dp           = dp_q;
  assign blank        = blank_q;
  assign digit_idx    = idx_q;
  assign digit_strobe = strobe_q;

endmodule

// File: doc/seg_display_sequencer.md
Name: seg_display_sequencer

Overview:
Downstream display stage for the dual 74181 ALU datapath. Consumes the 8-bit ALU result and the 8-bit flag byte, selects one nibble per configured mode, and presents it to the existing binary-to-7-segment decoder. In auto-scan mode a prescaled dwell timer steps through all four nibbles from a coherent snapshot. Selection comes from config register 3 bits [2:0].

Parameters:
PRESC_DIV, 1000, clk cycles per prescaler tick (>=2)
DWELL_TICKS, 250, ticks each digit is shown in auto-scan (>=1)

Ports:
clk  input  1  system clock
rstb  input  1  asynchronous active-low reset
ena  input  1  design enable; counters and state advance only when high
alu_f  input  8  ALU result F[7:0]
alu_flags  input  8  {c_out0,equal0,p0,g0,c_out1,equal1,p1,g1}
disp_sel  input  3  display mode select
nibble  output  4  value to the 7-seg decoder
dp  output  1  decimal point; lit when showing a flag nibble
blank  output  1  1 = decoder output must be suppressed
digit_idx  output  2  index of the nibble shown (0..3)
digit_strobe  output  1  one-cycle pulse when a new auto-scan digit is presented

Behaviour:
- Reset (async, rstb=0): nibble=0, dp=0, blank=1, digit_idx=0, digit_strobe=0; prescaler, dwell counter, mode register, snapshot all 0.
- Digit map: 0=alu_f[3:0], 1=alu_f[7:4], 2=alu_flags[3:0], 3=alu_flags[7:4]. dp=1 for digits 2,3.
- disp_sel 0..3: static; show that digit live; outputs registered, 1-cycle latency from alu_f/alu_flags; blank=0; digit_strobe=0.
- disp_sel 4: auto-scan from snapshot registers; blank=0.
- disp_sel 5..7: blank=1, nibble=0, dp=0, digit_idx=0.
- Mode register samples disp_sel every ena cycle. On a change (including into 4): prescaler=0, dwell=0, scan digit=0, snapshot<=alu_f/alu_flags at the same edge; outputs show the new mode next cycle.
- Prescaler: counts 0..PRESC_DIV-1 while ena; tick = one cycle at PRESC_DIV-1, then wraps to 0.
- Dwell: increments on tick; at DWELL_TICKS-1 with tick, wraps to 0 and scan digit advances 0->1->2->3->0.
- Entering digit 0 by wrap from 3 re-takes the snapshot; a full 4-digit scan always shows one coherent result.
- digit_strobe: high for exactly the cycle the new digit first appears on nibble (one cycle after the advancing tick). Not pulsed on mode entry.
- Digit period = PRESC_DIV*DWELL_TICKS cycles; full scan = 4x that.
- ena=0: all counters and registers hold; outputs hold.
- Static modes: prescaler and dwell held at 0.
- Simultaneous mode change and wrap: the mode change wins (counters cleared, digit 0).
- Counter widths: $clog2 of limits; no overflow past limits.

Optional Feature:
SEG_SCAN_GAP_EN: when defined, auto-scan inserts one blank tick after each digit's dwell. blank=1 and nibble=0 for PRESC_DIV cycles, and digit_idx still shows the outgoing digit. The next digit and digit_strobe then follow, so the digit period becomes PRESC_DIV*(DWELL_TICKS+1). When undefined, there is no gap and digits are back-to-back.

Test Plan:
- Reset: hold rstb=0 mid-scan with disp_sel=4 -> nibble=0, blank=1, digit_idx=0, digit_strobe=0 immediately (asynchronous).
- Static: disp_sel=1, alu_f=0xA5 -> nibble=0xA one cycle later, dp=0. Change alu_f to 0x3C -> nibble=0x3 next cycle.
- Flags: disp_sel=3, alu_flags=0x9E -> nibble=0x9, dp=1, digit_idx=3.
- Auto-scan (PRESC_DIV=4, DWELL_TICKS=2), alu_f=0x5A, alu_flags=0xC3, disp_sel 0->4:
  - nibble sequence A,5,3,C, each held 8 cycles;
  - digit_strobe pulses every 8 cycles;
  - changing alu_f mid-scan to 0xFF does not alter digits until the next wrap to digit 0.
- Mode change mid-dwell: disp_sel 4->6 -> blank=1 next cycle. Back to 4 -> restarts at digit 0 with a fresh snapshot and a full 8-cycle dwell.
- ena=0 for 20 cycles during auto-scan -> outputs frozen; the dwell remaining after ena returns is unchanged. With SEG_SCAN_GAP_EN: a 4-cycle blank appears between digits and the period is 12.
